// File: rtl/alu_arb_pkg.sv
// Types and constants shared by the ALU arbiter.
package alu_arb_pkg;
    // Arbiter FSM: wait for a request, evaluate it, hold the result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Requester identifiers, also used as the rsp_id encoding.
    localparam logic ID_A = 1'b0;
    localparam logic ID_B = 1'b1;
endpackage

// File: rtl/riscv_alu_constants.sv
// Operation encodings for the shared RISC-V style ALU.
// Every block that drives or decodes an alu_op imports these names
// instead of defining its own copies.
package riscv_alu_constants;
    localparam logic [3:0] ADD_OP      = 4'd0;
    localparam logic [3:0] SUB_OP      = 4'd1;
    localparam logic [3:0] AND_OP      = 4'd2;
    localparam logic [3:0] OR_OP       = 4'd3;
    localparam logic [3:0] XOR_OP      = 4'd4;
    localparam logic [3:0] LESS_OP     = 4'd5;
    localparam logic [3:0] LESS_U_OP   = 4'd6;
    localparam logic [3:0] LEFT_L_OP   = 4'd7;
    localparam logic [3:0] RIGHT_L_OP  = 4'd8;
    localparam logic [3:0] RIGHT_AR_OP = 4'd9;
endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU. Shift amounts use op2[4:0] only; any op code
// without a dedicated case behaves as an add.
module alu
    import riscv_alu_constants::*;
(
    input  logic [3:0]  alu_op,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    output logic [31:0] result
);

    logic [4:0] shamt;

    assign shamt = op2[4:0];

    // Evaluate the selected operation; default covers unknown codes.
    always_comb begin
        result = op1 + op2;
        case (alu_op)
            ADD_OP:      result = op1 + op2;
            SUB_OP:      result = op1 - op2;
            AND_OP:      result = op1 & op2;
            OR_OP:       result = op1 | op2;
            XOR_OP:      result = op1 ^ op2;
            LESS_OP:     result = {31'd0, ($signed(op1) < $signed(op2))};
            LESS_U_OP:   result = {31'd0, (op1 < op2)};
            LEFT_L_OP:   result = op1 << shamt;
            RIGHT_L_OP:  result = op1 >> shamt;
            RIGHT_AR_OP: result = $unsigned($signed(op1) >>> shamt);
            default:     result = op1 + op2;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between requesters A and B. A request is accepted in IDLE,
// its operands are registered, evaluated in EXEC, and the registered result
// is held in RESP until the consumer takes it. Operations never overlap.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Requesters hold valid and payload stable until they see ready;
// the response side holds rsp_valid and its payload stable until rsp_ready.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter bit FIXED_PRIORITY = 1'b0,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [31:0]      a_op1,
    input  logic [31:0]      a_op2,
    input  logic [3:0]       a_alu_op,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [31:0]      b_op1,
    input  logic [31:0]      b_op2,
    input  logic [3:0]       b_alu_op,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [31:0]      rsp_result,
    output logic             rsp_zero,
    output logic             busy,
    output logic [CNT_W-1:0] ops_done,
    output logic [1:0]       dbg_state
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t             state_q;
    logic               rr_ptr_q;
    logic               gnt_id_q;
    logic [31:0]        op1_q;
    logic [31:0]        op2_q;
    logic [3:0]         alu_op_q;
    logic               rsp_valid_q;
    logic               rsp_id_q;
    logic [31:0]        rsp_result_q;
    logic               rsp_zero_q;
    logic [CNT_W-1:0]   ops_done_q;

    logic               in_idle;
    logic               gnt_id;
    logic [31:0]        alu_result;

    // A sole requester always wins; a tie goes to A under fixed priority,
    // otherwise to the side named by the round-robin pointer.
    function automatic logic pick_winner(input logic av, input logic bv, input logic pref);
        if (av && !bv) return ID_A;
        if (bv && !av) return ID_B;
        return FIXED_PRIORITY ? ID_A : pref;
    endfunction

    assign in_idle = (state_q == IDLE);
    assign gnt_id  = pick_winner(a_valid, b_valid, rr_ptr_q);
    assign a_ready = in_idle && a_valid && (gnt_id == ID_A);
    assign b_ready = in_idle && b_valid && (gnt_id == ID_B);

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_zero   = rsp_zero_q;
    assign ops_done   = ops_done_q;
    assign busy       = !in_idle;
    assign dbg_state  = state_q;

    // The ALU only ever sees the captured operands, never live requester inputs.
    alu u_alu (
        .alu_op (alu_op_q),
        .op1    (op1_q),
        .op2    (op2_q),
        .result (alu_result)
    );

    // Arbiter FSM with registered response outputs and completion counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            rr_ptr_q     <= ID_A;
            gnt_id_q     <= ID_A;
            op1_q        <= '0;
            op2_q        <= '0;
            alu_op_q     <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= ID_A;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            ops_done_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (a_ready) begin
                        op1_q    <= a_op1;
                        op2_q    <= a_op2;
                        alu_op_q <= a_alu_op;
                        gnt_id_q <= ID_A;
                        state_q  <= EXEC;
                    end else if (b_ready) begin
                        op1_q    <= b_op1;
                        op2_q    <= b_op2;
                        alu_op_q <= b_alu_op;
                        gnt_id_q <= ID_B;
                        state_q  <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_result_q <= alu_result;
                    rsp_zero_q   <= (alu_result == 32'd0);
                    rsp_id_q     <= gnt_id_q;
                    rsp_valid_q  <= 1'b1;
                    state_q      <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        ops_done_q  <= ops_done_q + CNT_ONE;
                        rr_ptr_q    <= ~gnt_id_q;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter. Instance 0 is round-robin, instance 1 fixed priority.
// Expected results come from an arithmetic ALU reference and an arbitration
// model expressed as "who is waiting, who was served last".
`timescale 1ns/1ps
module tb_alu_arbiter;
    import riscv_alu_constants::*;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] x;
        logic [31:0] y;
    } req_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst        [2];
    logic        a_valid    [2];
    logic        a_ready    [2];
    logic [31:0] a_op1      [2];
    logic [31:0] a_op2      [2];
    logic [3:0]  a_alu_op   [2];
    logic        b_valid    [2];
    logic        b_ready    [2];
    logic [31:0] b_op1      [2];
    logic [31:0] b_op2      [2];
    logic [3:0]  b_alu_op   [2];
    logic        rsp_valid  [2];
    logic        rsp_ready  [2];
    logic        rsp_id     [2];
    logic [31:0] rsp_result [2];
    logic        rsp_zero   [2];
    logic        busy       [2];
    logic [15:0] ops_done   [2];
    logic [1:0]  dbg_state  [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        alu_arbiter #(.FIXED_PRIORITY(g == 1), .CNT_W(16)) dut (
            .clk        (clk),
            .rst        (rst[g]),
            .a_valid    (a_valid[g]),
            .a_ready    (a_ready[g]),
            .a_op1      (a_op1[g]),
            .a_op2      (a_op2[g]),
            .a_alu_op   (a_alu_op[g]),
            .b_valid    (b_valid[g]),
            .b_ready    (b_ready[g]),
            .b_op1      (b_op1[g]),
            .b_op2      (b_op2[g]),
            .b_alu_op   (b_alu_op[g]),
            .rsp_valid  (rsp_valid[g]),
            .rsp_ready  (rsp_ready[g]),
            .rsp_id     (rsp_id[g]),
            .rsp_result (rsp_result[g]),
            .rsp_zero   (rsp_zero[g]),
            .busy       (busy[g]),
            .ops_done   (ops_done[g]),
            .dbg_state  (dbg_state[g])
        );
    end

    int checks = 0;
    int errors = 0;

    // Model state and scoreboard
    logic        m_pref [2];   // side preferred on a tie: 0 = A, 1 = B
    logic [15:0] m_ops  [2];
    req_t        aq[$];
    req_t        bq[$];
    logic [32:0] exp_q[$];     // {id, result}
    logic        svd_id[$];
    logic [31:0] svd_res[$];
    int          br_early;

    function automatic req_t mk_req(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        req_t r;
        r.op = op;
        r.x  = x;
        r.y  = y;
        return r;
    endfunction

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    // ALU behaviour from plain arithmetic.
    function automatic logic [31:0] ref_alu(input req_t r);
        logic [31:0] ones;
        int s;
        ones = 32'hFFFF_FFFF;
        s = int'(r.y % 32);
        case (r.op)
            SUB_OP:      return r.x - r.y;
            AND_OP:      return r.x & r.y;
            OR_OP:       return r.x | r.y;
            XOR_OP:      return r.x ^ r.y;
            LESS_OP:     return (int'(r.x) < int'(r.y)) ? 32'd1 : 32'd0;
            LESS_U_OP:   return (r.x < r.y) ? 32'd1 : 32'd0;
            LEFT_L_OP:   return r.x << s;
            RIGHT_L_OP:  return r.x >> s;
            RIGHT_AR_OP: return (r.x >> s) | ((r.x >= 32'h8000_0000) ? ~(ones >> s) : 32'd0);
            default:     return r.x + r.y;
        endcase
    endfunction

    task automatic do_reset(input int i);
        rst[i] = 1'b1;
        a_valid[i] = 1'b0; b_valid[i] = 1'b0; rsp_ready[i] = 1'b0;
        a_op1[i] = '0; a_op2[i] = '0; a_alu_op[i] = '0;
        b_op1[i] = '0; b_op2[i] = '0; b_alu_op[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        rst[i] = 1'b0;
        m_pref[i] = 1'b0;
        m_ops[i] = '0;
    endtask

    // Drives queued requests from A and B into instance i and checks every
    // cycle against the model until all requests have been answered.
    task automatic run_traffic(input int i, input int vpct, input int rpct, input int budget);
        logic on_a = 1'b0;
        logic on_b = 1'b0;
        logic busy_m = 1'b0;
        logic win, exp_ar, exp_br, rv_exp;
        int age = 0;
        int n = 0;
        logic [32:0] e;
        exp_q.delete(); svd_id.delete(); svd_res.delete();
        br_early = 0;
        while (aq.size() > 0 || bq.size() > 0 || busy_m) begin
            if (n == budget) begin
                checks++; errors++;
                $display("FAIL timeout inst%0d: %0d+%0d requests pending after %0d cycles, required 0",
                         i, aq.size(), bq.size(), n);
                break;
            end
            n++;
            if (!on_a && aq.size() > 0 && $urandom_range(0, 99) < vpct) on_a = 1'b1;
            if (!on_b && bq.size() > 0 && $urandom_range(0, 99) < vpct) on_b = 1'b1;
            a_valid[i] = on_a;
            b_valid[i] = on_b;
            if (on_a) begin a_alu_op[i] = aq[0].op; a_op1[i] = aq[0].x; a_op2[i] = aq[0].y; end
            else begin a_alu_op[i] = 4'($urandom); a_op1[i] = $urandom; a_op2[i] = $urandom; end
            if (on_b) begin b_alu_op[i] = bq[0].op; b_op1[i] = bq[0].x; b_op2[i] = bq[0].y; end
            else begin b_alu_op[i] = 4'($urandom); b_op1[i] = $urandom; b_op2[i] = $urandom; end
            rsp_ready[i] = ($urandom_range(0, 99) < rpct);
            #1;
            if (on_a && on_b) win = (i == 1) ? 1'b0 : m_pref[i];
            else win = on_b;
            exp_ar = !busy_m && on_a && (win == 1'b0);
            exp_br = !busy_m && on_b && (win == 1'b1);
            rv_exp = busy_m && (age >= 2);

            checks++;
            if (a_ready[i] !== exp_ar) begin
                errors++; $display("FAIL a_ready inst%0d cyc%0d: got %b want %b", i, n, a_ready[i], exp_ar);
            end
            checks++;
            if (b_ready[i] !== exp_br) begin
                errors++; $display("FAIL b_ready inst%0d cyc%0d: got %b want %b", i, n, b_ready[i], exp_br);
            end
            checks++;
            if (busy[i] !== busy_m) begin
                errors++; $display("FAIL busy inst%0d cyc%0d: got %b want %b", i, n, busy[i], busy_m);
            end
            checks++;
            if (rsp_valid[i] !== rv_exp) begin
                errors++; $display("FAIL rsp_valid inst%0d cyc%0d: got %b want %b", i, n, rsp_valid[i], rv_exp);
            end
            checks++;
            if (ops_done[i] !== m_ops[i]) begin
                errors++; $display("FAIL ops_done inst%0d cyc%0d: got %0d want %0d", i, n, ops_done[i], m_ops[i]);
            end
            if (rv_exp) begin
                e = exp_q[0];
                checks++;
                if (rsp_id[i] !== e[32] || rsp_result[i] !== e[31:0] || rsp_zero[i] !== (e[31:0] == 32'd0)) begin
                    errors++;
                    $display("FAIL rsp_data inst%0d cyc%0d: got id=%b res=%h z=%b want id=%b res=%h z=%b",
                             i, n, rsp_id[i], rsp_result[i], rsp_zero[i], e[32], e[31:0], (e[31:0] == 32'd0));
                end
            end
            if (b_ready[i] === 1'b1 && aq.size() > 0) br_early++;

            if (rv_exp && rsp_ready[i]) begin
                e = exp_q.pop_front();
                svd_id.push_back(e[32]);
                svd_res.push_back(e[31:0]);
                m_ops[i] = m_ops[i] + 16'd1;
                m_pref[i] = ~e[32];
                busy_m = 1'b0;
            end else if (busy_m) begin
                age++;
            end
            if (exp_ar) begin
                exp_q.push_back({1'b0, ref_alu(aq[0])});
                void'(aq.pop_front());
                on_a = 1'b0; busy_m = 1'b1; age = 1;
            end else if (exp_br) begin
                exp_q.push_back({1'b1, ref_alu(bq[0])});
                void'(bq.pop_front());
                on_b = 1'b0; busy_m = 1'b1; age = 1;
            end
            @(posedge clk); #1;
        end
        a_valid[i] = 1'b0;
        b_valid[i] = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1;
            a_valid[i] = 1'b0; b_valid[i] = 1'b0; rsp_ready[i] = 1'b0;
            a_op1[i] = '0; a_op2[i] = '0; a_alu_op[i] = '0;
            b_op1[i] = '0; b_op2[i] = '0; b_alu_op[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst[0] = 1'b0; rst[1] = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            m_pref[i] = 1'b0; m_ops[i] = '0;
            checks++;
            if (rsp_valid[i] !== 1'b0 || rsp_id[i] !== 1'b0 || rsp_zero[i] !== 1'b0 || busy[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset_flags inst%0d: got v=%b id=%b z=%b busy=%b want all 0",
                         i, rsp_valid[i], rsp_id[i], rsp_zero[i], busy[i]);
            end
            checks++;
            if (rsp_result[i] !== 32'd0 || ops_done[i] !== 16'd0 || dbg_state[i] !== 2'd0) begin
                errors++;
                $display("FAIL reset_values inst%0d: got res=%h ops=%0d st=%0d want 0 0 0",
                         i, rsp_result[i], ops_done[i], dbg_state[i]);
            end
            checks++;
            if (a_ready[i] !== 1'b0 || b_ready[i] !== 1'b0) begin
                errors++; $display("FAIL reset_ready inst%0d: got %b%b want 00", i, a_ready[i], b_ready[i]);
            end
        end
    endtask

    task automatic test_single_a();
        do_reset(0);
        a_valid[0] = 1'b1; a_op1[0] = 32'd5; a_op2[0] = 32'd7; a_alu_op[0] = ADD_OP;
        rsp_ready[0] = 1'b1;
        #1;
        checks++;
        if (a_ready[0] !== 1'b1 || b_ready[0] !== 1'b0) begin
            errors++; $display("FAIL single_ready: got a=%b b=%b want a=1 b=0", a_ready[0], b_ready[0]);
        end
        @(posedge clk); #1;
        a_valid[0] = 1'b0;
        #1;
        checks++;
        if (rsp_valid[0] !== 1'b0 || busy[0] !== 1'b1) begin
            errors++; $display("FAIL single_exec: got v=%b busy=%b want v=0 busy=1", rsp_valid[0], busy[0]);
        end
        @(posedge clk); #2;
        checks++;
        if (rsp_valid[0] !== 1'b1 || rsp_result[0] !== 32'd12 || rsp_zero[0] !== 1'b0 || rsp_id[0] !== 1'b0) begin
            errors++;
            $display("FAIL single_resp: got v=%b res=%0d z=%b id=%b want v=1 res=12 z=0 id=0",
                     rsp_valid[0], rsp_result[0], rsp_zero[0], rsp_id[0]);
        end
        @(posedge clk); #2;
        checks++;
        if (rsp_valid[0] !== 1'b0 || ops_done[0] !== 16'd1 || busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL single_done: got v=%b ops=%0d busy=%b want v=0 ops=1 busy=0",
                     rsp_valid[0], ops_done[0], busy[0]);
        end
        rsp_ready[0] = 1'b0;
    endtask

    task automatic test_rr_pair();
        logic exp_ids [4];
        exp_ids = '{1'b0, 1'b1, 1'b0, 1'b1};
        do_reset(0);
        aq.delete(); bq.delete();
        aq.push_back(mk_req(SUB_OP, 32'd9, 32'd9));
        aq.push_back(mk_req(ADD_OP, 32'd100, 32'd23));
        bq.push_back(mk_req(XOR_OP, 32'h0000_F0F0, 32'h0000_0F0F));
        bq.push_back(mk_req(OR_OP, 32'h1, 32'h2));
        run_traffic(0, 100, 100, 200);
        checks++;
        if (svd_id.size() != 4) begin
            errors++; $display("FAIL rr_count: got %0d responses want 4", svd_id.size());
        end
        for (int k = 0; k < svd_id.size() && k < 4; k++) begin
            checks++;
            if (svd_id[k] !== exp_ids[k]) begin
                errors++; $display("FAIL rr_order[%0d]: got id %b want %b", k, svd_id[k], exp_ids[k]);
            end
        end
        checks++;
        if (svd_res.size() < 2 || svd_res[0] !== 32'd0 || svd_res[1] !== 32'h0000_FFFF) begin
            errors++; $display("FAIL rr_results: got %0d responses, want first two 0 and 0000ffff", svd_res.size());
        end
    endtask

    task automatic test_fixed_priority();
        do_reset(1);
        aq.delete(); bq.delete();
        for (int k = 0; k < 3; k++) aq.push_back(mk_req(4'($urandom_range(0, 15)), rnd_val(), rnd_val()));
        bq.push_back(mk_req(ADD_OP, 32'd1, 32'd1));
        run_traffic(1, 100, 100, 300);
        checks++;
        if (br_early != 0) begin
            errors++; $display("FAIL fixed_b_ready: b_ready rose %0d times while A pending, want 0", br_early);
        end
        for (int k = 0; k < 3 && k < svd_id.size(); k++) begin
            checks++;
            if (svd_id[k] !== 1'b0) begin
                errors++; $display("FAIL fixed_id[%0d]: got %b want 0", k, svd_id[k]);
            end
        end
        checks++;
        if (svd_id.size() != 4) begin
            errors++; $display("FAIL fixed_count: got %0d responses want 4", svd_id.size());
        end
    endtask

    task automatic test_backpressure();
        int bad;
        do_reset(0);
        a_valid[0] = 1'b1; a_op1[0] = 32'h1234; a_op2[0] = 32'h1; a_alu_op[0] = ADD_OP;
        rsp_ready[0] = 1'b0;
        @(posedge clk); #1;
        a_valid[0] = 1'b0;
        b_valid[0] = 1'b1; b_op1[0] = 32'd100; b_op2[0] = 32'd1; b_alu_op[0] = SUB_OP;
        @(posedge clk); #1;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (rsp_valid[0] !== 1'b1 || rsp_result[0] !== 32'h1235 || rsp_id[0] !== 1'b0 ||
                a_ready[0] !== 1'b0 || b_ready[0] !== 1'b0 || busy[0] !== 1'b1) bad++;
            @(posedge clk); #1;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL bp_hold: %0d of 10 stalled cycles wrong, want 0", bad);
        end
        rsp_ready[0] = 1'b1;
        @(posedge clk); #2;
        checks++;
        if (rsp_valid[0] !== 1'b0 || ops_done[0] !== 16'd1) begin
            errors++; $display("FAIL bp_release: got v=%b ops=%0d want v=0 ops=1", rsp_valid[0], ops_done[0]);
        end
        checks++;
        if (b_ready[0] !== 1'b1 || a_ready[0] !== 1'b0) begin
            errors++; $display("FAIL bp_loser_wins: got a=%b b=%b want a=0 b=1", a_ready[0], b_ready[0]);
        end
        @(posedge clk); #1;
        b_valid[0] = 1'b0;
        @(posedge clk); #2;
        checks++;
        if (rsp_valid[0] !== 1'b1 || rsp_result[0] !== 32'd99 || rsp_id[0] !== 1'b1 || rsp_zero[0] !== 1'b0) begin
            errors++;
            $display("FAIL bp_b_resp: got v=%b res=%0d id=%b z=%b want v=1 res=99 id=1 z=0",
                     rsp_valid[0], rsp_result[0], rsp_id[0], rsp_zero[0]);
        end
        @(posedge clk); #2;
        checks++;
        if (ops_done[0] !== 16'd2 || rsp_valid[0] !== 1'b0) begin
            errors++; $display("FAIL bp_b_done: got ops=%0d v=%b want ops=2 v=0", ops_done[0], rsp_valid[0]);
        end
        rsp_ready[0] = 1'b0;
    endtask

    task automatic test_shifts_compare();
        logic [31:0] want [3];
        want = '{32'hF800_0000, 32'h0000_0001, 32'h8000_0000};
        do_reset(0);
        aq.delete(); bq.delete();
        aq.push_back(mk_req(RIGHT_AR_OP, 32'h8000_0000, 32'h0000_0024));
        aq.push_back(mk_req(LESS_OP, 32'hFFFF_FFFF, 32'h0000_0001));
        aq.push_back(mk_req(LEFT_L_OP, 32'h0000_0001, 32'd31));
        run_traffic(0, 100, 100, 200);
        checks++;
        if (svd_res.size() != 3) begin
            errors++; $display("FAIL shift_count: got %0d responses want 3", svd_res.size());
        end
        for (int k = 0; k < svd_res.size() && k < 3; k++) begin
            checks++;
            if (svd_res[k] !== want[k]) begin
                errors++; $display("FAIL shift_result[%0d]: got %h want %h", k, svd_res[k], want[k]);
            end
        end
    endtask

    task automatic test_reset_exec();
        int bad;
        do_reset(0);
        a_valid[0] = 1'b1; a_op1[0] = 32'd3; a_op2[0] = 32'd4; a_alu_op[0] = ADD_OP;
        rsp_ready[0] = 1'b1;
        @(posedge clk); #1;
        a_valid[0] = 1'b0;
        rst[0] = 1'b1;
        #1;
        checks++;
        if (busy[0] !== 1'b1) begin
            errors++; $display("FAIL rexec_in_exec: got busy=%b want 1", busy[0]);
        end
        @(posedge clk); #1;
        rst[0] = 1'b0;
        #1;
        checks++;
        if (busy[0] !== 1'b0 || rsp_valid[0] !== 1'b0 || ops_done[0] !== 16'd0) begin
            errors++;
            $display("FAIL rexec_idle: got busy=%b v=%b ops=%0d want 0 0 0", busy[0], rsp_valid[0], ops_done[0]);
        end
        bad = 0;
        repeat (5) begin
            if (rsp_valid[0] !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL rexec_no_rsp: rsp_valid high in %0d cycles want 0", bad);
        end
        m_pref[0] = 1'b0; m_ops[0] = '0;
        aq.delete(); bq.delete();
        aq.push_back(mk_req(ADD_OP, 32'd10, 32'd20));
        run_traffic(0, 100, 100, 100);
        checks++;
        if (svd_res.size() != 1 || svd_res[0] !== 32'd30) begin
            errors++; $display("FAIL rexec_after: got %0d responses, first %h want 1 response 0000001e",
                               svd_res.size(), svd_res.size() > 0 ? svd_res[0] : 32'd0);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 2; i++) begin
            do_reset(i);
            aq.delete(); bq.delete();
            for (int k = 0; k < 25; k++) begin
                aq.push_back(mk_req(4'($urandom_range(0, 15)), rnd_val(), rnd_val()));
                bq.push_back(mk_req(4'($urandom_range(0, 15)), rnd_val(), rnd_val()));
            end
            run_traffic(i, 40, 60, 4000);
            checks++;
            if (svd_id.size() != 50) begin
                errors++; $display("FAIL random_count inst%0d: got %0d responses want 50", i, svd_id.size());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_a();
        test_rr_pair();
        test_fixed_priority();
        test_backpressure();
        test_shifts_compare();
        test_reset_exec();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
